// File: rtl/conv_window_3x3_if.sv
// Pixel-stream interface between a raster pixel source and the 3x3 window stage.
// The master drives pixels and the frame restart; the slave returns windows.
interface conv_window_3x3_if #(
    parameter int unsigned DATA_W = 10
);
    logic                  i_clear;
    logic                  i_valid;
    logic [DATA_W-1:0]     i_pixel;
    logic                  o_valid;
    logic [9*DATA_W-1:0]   o_window;
    logic                  o_frame_done;

    modport master (
        output i_clear,
        output i_valid,
        output i_pixel,
        input  o_valid,
        input  o_window,
        input  o_frame_done
    );

    modport slave (
        input  i_clear,
        input  i_valid,
        input  i_pixel,
        output o_valid,
        output o_window,
        output o_frame_done
    );
endinterface

// File: rtl/conv_window_3x3.sv
// Streaming line-buffer stage: turns a raster pixel stream into packed 3x3 windows
// ("valid" windowing only, so a W x H frame yields (W-2) x (H-2) windows).
module conv_window_3x3 #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    conv_window_3x3_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              col_last, row_last;
    logic              accept;
    logic              valid_q, done_q;
    logic [DATA_W-1:0] win_q [9];

    // lb0 holds the previous row, lb1 the row before that
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];

    always_comb begin
        accept   = bus.i_valid && !bus.i_clear;
        col_last = (col_q == COL_LAST);
        row_last = (row_q == ROW_LAST);
        col_d    = col_q;
        row_d    = row_q;
        if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + ROW_W'(1);
        end else begin
            col_d = col_q + COL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else if (bus.i_clear) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.i_valid) begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
            done_q  <= row_last && col_last;
            for (int r = 0; r < 3; r++) begin
                win_q[3*r]     <= win_q[3*r + 1];
                win_q[3*r + 1] <= win_q[3*r + 2];
            end
            win_q[2] <= lb1[col_q];
            win_q[5] <= lb0[col_q];
            win_q[8] <= bus.i_pixel;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end
    end

    // Line buffers carry no reset so they can map onto plain RAM; read-before-write.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= bus.i_pixel;
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign bus.o_window[k*DATA_W +: DATA_W] = win_q[k];
    end

    assign bus.o_valid      = valid_q;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3: a 4x4 instance for the directed and random
// scenarios, and a default 32x32 instance for the full-size stream.
module tb_conv_window_3x3;
    logic clk = 1'b0;
    logic rstn_s, rstn_l;

    always #5 clk = ~clk;

    conv_window_3x3_if #(.DATA_W(10)) bus_s ();
    conv_window_3x3_if #(.DATA_W(10)) bus_l ();

    conv_window_3x3 #(.DATA_W(10), .IMG_W(4), .IMG_H(4)) dut_s (
        .i_clk  (clk),
        .i_rstn (rstn_s),
        .bus    (bus_s.slave)
    );

    conv_window_3x3 #(.DATA_W(10), .IMG_W(32), .IMG_H(32)) dut_l (
        .i_clk  (clk),
        .i_rstn (rstn_l),
        .bus    (bus_l.slave)
    );

    typedef struct {
        logic [9:0]  px;
        bit          ev;
        bit          ed;
        logic [89:0] ew;
    } vec_t;

    vec_t        tbl [16];
    int          total = 0;
    int          bad = 0;
    bit          sel = 1'b0;
    int          mw = 4;
    int          mh = 4;
    int          mdl_n = 0;
    logic [9:0]  img [32][32];
    int          win_cnt = 0;
    int          done_cnt = 0;

    function automatic logic [89:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7, input int a8);
        logic [89:0] w;
        w[9:0]   = 10'(a0); w[19:10] = 10'(a1); w[29:20] = 10'(a2);
        w[39:30] = 10'(a3); w[49:40] = 10'(a4); w[59:50] = 10'(a5);
        w[69:60] = 10'(a6); w[79:70] = 10'(a7); w[89:80] = 10'(a8);
        return w;
    endfunction

    task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare on the falling edge.
    task automatic step(input bit v, input bit clr, input logic [9:0] px,
                        input bit ev, input bit ed, input logic [89:0] ew);
        logic        ov, od;
        logic [89:0] ow;
        if (!sel) begin
            bus_s.i_valid = v; bus_s.i_clear = clr; bus_s.i_pixel = px;
            bus_l.i_valid = 1'b0; bus_l.i_clear = 1'b0; bus_l.i_pixel = '0;
        end else begin
            bus_l.i_valid = v; bus_l.i_clear = clr; bus_l.i_pixel = px;
            bus_s.i_valid = 1'b0; bus_s.i_clear = 1'b0; bus_s.i_pixel = '0;
        end
        @(posedge clk);
        @(negedge clk);
        ov = sel ? bus_l.o_valid      : bus_s.o_valid;
        od = sel ? bus_l.o_frame_done : bus_s.o_frame_done;
        ow = sel ? bus_l.o_window     : bus_s.o_window;
        if (ov === 1'b1) win_cnt++;
        if (od === 1'b1) done_cnt++;
        chk("o_valid", 90'(ov), 90'(ev));
        chk("o_frame_done", 90'(od), 90'(ed));
        if (ev) chk("o_window", ow, ew);
    endtask

    // Reference: pixel n of a frame lands at (n / W, n % W); a window exists once
    // the pixel's row and column are both >= 2 and spans the 3x3 block ending there.
    task automatic mstep(input bit v, input bit clr, input logic [9:0] px);
        int          r, c;
        bit          ev = 1'b0;
        bit          ed = 1'b0;
        logic [89:0] ew = '0;
        if (clr) begin
            mdl_n = 0;
        end else if (v) begin
            r = mdl_n / mw;
            c = mdl_n % mw;
            img[r][c] = px;
            if (r >= 2 && c >= 2) begin
                ev = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[(3*i + j)*10 +: 10] = img[r - 2 + i][c - 2 + j];
            end
            ed = (mdl_n == mw*mh - 1);
            mdl_n = (mdl_n + 1) % (mw*mh);
        end
        step(v, clr, px, ev, ed, ew);
    endtask

    task automatic run_table(input int off, input bit gaps);
        logic [89:0] w;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
            end
            w = tbl[i].ew;
            for (int k = 0; k < 9; k++) w[k*10 +: 10] = w[k*10 +: 10] + 10'(off);
            step(1'b1, 1'b0, tbl[i].px + 10'(off), tbl[i].ev, tbl[i].ed, w);
        end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].px = 10'(i);
            tbl[i].ev = 1'b0;
            tbl[i].ed = 1'b0;
            tbl[i].ew = '0;
        end
        tbl[10].ev = 1'b1; tbl[10].ew = pk(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tbl[11].ev = 1'b1; tbl[11].ew = pk(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[14].ev = 1'b1; tbl[14].ew = pk(4, 5, 6, 8, 9, 10, 12, 13, 14);
        tbl[15].ev = 1'b1; tbl[15].ew = pk(5, 6, 7, 9, 10, 11, 13, 14, 15);
        tbl[15].ed = 1'b1;

        bus_s.i_valid = 1'b0; bus_s.i_clear = 1'b0; bus_s.i_pixel = '0;
        bus_l.i_valid = 1'b0; bus_l.i_clear = 1'b0; bus_l.i_pixel = '0;
        rstn_s = 1'b0;
        rstn_l = 1'b0;
        #1;
        chk("rst_valid_s", 90'(bus_s.o_valid), '0);
        chk("rst_window_s", bus_s.o_window, '0);
        chk("rst_done_s", 90'(bus_s.o_frame_done), '0);
        chk("rst_valid_l", 90'(bus_l.o_valid), '0);
        chk("rst_window_l", bus_l.o_window, '0);
        @(negedge clk);
        @(negedge clk);
        rstn_s = 1'b1;
        rstn_l = 1'b1;

        // Back-to-back frame, gapped frame, then two frames in a row
        run_table(0, 1'b0);
        run_table(0, 1'b1);
        run_table(0, 1'b0);
        run_table(100, 1'b0);

        // Asynchronous reset after pixel 9
        mdl_n = 0;
        for (int i = 0; i < 10; i++) mstep(1'b1, 1'b0, 10'(i));
        #2 rstn_s = 1'b0;
        #1;
        chk("midrst_valid", 90'(bus_s.o_valid), '0);
        chk("midrst_window", bus_s.o_window, '0);
        chk("midrst_done", 90'(bus_s.o_frame_done), '0);
        @(negedge clk);
        chk("midrst_window_hold", bus_s.o_window, '0);
        rstn_s = 1'b1;
        mdl_n = 0;
        run_table(0, 1'b0);

        // Clear with a valid pixel 7 mid-frame: pixel is dropped
        for (int i = 0; i < 7; i++) mstep(1'b1, 1'b0, 10'(i));
        mstep(1'b1, 1'b1, 10'd7);
        run_table(0, 1'b0);

        // Random pixels, gaps and occasional clears
        for (int i = 0; i < 300; i++) begin
            mstep(($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
                  10'($urandom_range(0, 1023)));
        end
        mstep(1'b0, 1'b1, '0);

        // Full-size instance: two frames of an incrementing stream
        sel = 1'b1;
        mw = 32;
        mh = 32;
        mdl_n = 0;
        win_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 2048; i++) mstep(1'b1, 1'b0, 10'(i % 1024));
        mstep(1'b0, 1'b0, '0);
        chk("window_count", 90'(win_cnt), 90'(1800));
        chk("frame_done_count", 90'(done_cnt), 90'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
